// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and op encodings for the FIFO pointer/flag controller.
// Optional sticky error flags are enabled with the FIFO_CTRL_ERR_FLAGS_EN macro.
package fifo_ctrl_pkg;

  localparam int N_DEFAULT = 3;
  localparam int DEPTH     = 2 ** N_DEFAULT;

  // Encoded as {wr_ok, rd_ok}
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// Modulo-2**N pointer register used for both the write and read side of the FIFO.
module fifo_ptr #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [N-1:0] ptr,
  output logic [N-1:0] ptr_next
);

  logic [N-1:0] r_ptr;

  // Natural N-bit overflow gives the wrap from 2**N-1 back to 0
  assign ptr_next = r_ptr + N'(1);
  assign ptr      = r_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller turning a register file into a circular FIFO.
// Define FIFO_CTRL_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         rd,
  output logic         we,
  output logic [N-1:0] w_addr,
  output logic [N-1:0] r_addr,
  output logic         full,
  output logic         empty,
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  output logic [N:0]   count,
  output logic         overflow,
  output logic         underflow
`else
  output logic [N:0]   count
`endif
);

  logic         w_wrOk;
  logic         w_rdOk;
  op_e          w_op;
  logic [N-1:0] w_wPtrNext;
  logic [N-1:0] w_rPtrNext;

  logic         r_full;
  logic         r_empty;
  logic [N:0]   r_count;

  logic         w_fullNext;
  logic         w_emptyNext;
  logic [N:0]   w_countNext;

  assign w_wrOk = wr & ~r_full;
  assign w_rdOk = rd & ~r_empty;
  assign w_op   = op_e'({w_wrOk, w_rdOk});

  fifo_ptr #(.N(N)) u_wPtr (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_wrOk),
    .ptr      (w_addr),
    .ptr_next (w_wPtrNext)
  );

  fifo_ptr #(.N(N)) u_rPtr (
    .clk      (clk),
    .reset    (reset),
    .inc      (w_rdOk),
    .ptr      (r_addr),
    .ptr_next (w_rPtrNext)
  );

  // Flags are decided from pointer collision so full/empty are ready as registers
  always_comb begin
    w_fullNext  = r_full;
    w_emptyNext = r_empty;
    w_countNext = r_count;
    case (w_op)
      OP_WR: begin
        w_countNext = r_count + (N+1)'(1);
        w_emptyNext = 1'b0;
        w_fullNext  = (w_wPtrNext == r_addr);
      end
      OP_RD: begin
        w_countNext = r_count - (N+1)'(1);
        w_fullNext  = 1'b0;
        w_emptyNext = (w_rPtrNext == w_addr);
      end
      OP_BOTH, OP_NONE: begin
        w_countNext = r_count;
      end
      default: begin
        w_countNext = r_count;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_count <= '0;
    end else begin
      r_full  <= w_fullNext;
      r_empty <= w_emptyNext;
      r_count <= w_countNext;
    end
  end

  assign we    = w_wrOk;
  assign full  = r_full;
  assign empty = r_empty;
  assign count = r_count;

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // A write while empty is not an underflow since the write still lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow | (wr & r_full);
      r_underflow <= r_underflow | (rd & r_empty & ~wr);
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: occupancy model feeding a scoreboard queue.
module tb_fifo_ctrl;

  localparam int N     = 3;
  localparam int DEPTH = 8;

  typedef struct {
    logic [N:0]   count;
    logic         full;
    logic         empty;
    logic [N-1:0] wAddr;
    logic [N-1:0] rAddr;
    logic         ovf;
    logic         unf;
  } expect_t;

  logic         clk;
  logic         reset;
  logic         wr;
  logic         rd;
  logic         we;
  logic [N-1:0] wAddr;
  logic [N-1:0] rAddr;
  logic         full;
  logic         empty;
  logic [N:0]   count;
  logic         overflow;
  logic         underflow;

  int checks   = 0;
  int failures = 0;

  expect_t      scoreboard[$];
  logic [N-1:0] mW;
  logic [N-1:0] mR;
  int           mCount;
  logic         mOvf;
  logic         mUnf;

  fifo_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .rd        (rd),
    .we        (we),
    .w_addr    (wAddr),
    .r_addr    (rAddr),
    .full      (full),
    .empty     (empty),
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
`else
    .count     (count)
`endif
  );

`ifndef FIFO_CTRL_ERR_FLAGS_EN
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mW     = '0;
    mR     = '0;
    mCount = 0;
    mOvf   = 1'b0;
    mUnf   = 1'b0;
    scoreboard.delete();
  endtask

  // Drive one cycle of wr/rd, predict the post-edge state, then score it
  task automatic applyStimulus(input logic iWr, input logic iRd, input string tag);
    expect_t e;
    logic mFull, mEmpty, wOk, rOk;
    @(negedge clk);
    wr = iWr;
    rd = iRd;
    mFull  = (mCount == DEPTH);
    mEmpty = (mCount == 0);
    wOk = iWr && !mFull;
    rOk = iRd && !mEmpty;
    #1;
    checkOutput({tag, ".we"}, 32'(we), 32'(wOk));
    if (iWr && mFull) mOvf = 1'b1;
    if (iRd && mEmpty && !iWr) mUnf = 1'b1;
    if (wOk) mW = mW + 3'd1;
    if (rOk) mR = mR + 3'd1;
    if (wOk && !rOk) mCount++;
    if (rOk && !wOk) mCount--;
    e.count = (N+1)'(mCount);
    e.full  = (mCount == DEPTH);
    e.empty = (mCount == 0);
    e.wAddr = mW;
    e.rAddr = mR;
    e.ovf   = mOvf;
    e.unf   = mUnf;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    checkState(tag);
  endtask

  task automatic checkState(input string tag);
    expect_t e;
    if (scoreboard.size() == 0) begin
      checkOutput({tag, ".sbEmpty"}, 32'd0, 32'd1);
      return;
    end
    e = scoreboard.pop_front();
    checkOutput({tag, ".count"}, 32'(count), 32'(e.count));
    checkOutput({tag, ".full"},  32'(full),  32'(e.full));
    checkOutput({tag, ".empty"}, 32'(empty), 32'(e.empty));
    checkOutput({tag, ".waddr"}, 32'(wAddr), 32'(e.wAddr));
    checkOutput({tag, ".raddr"}, 32'(rAddr), 32'(e.rAddr));
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    checkOutput({tag, ".ovf"}, 32'(overflow),  32'(e.ovf));
    checkOutput({tag, ".unf"}, 32'(underflow), 32'(e.unf));
`endif
  endtask

  task automatic doReset();
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    reset = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    $display("[TB] fifo_ctrl bench start");
    wr = 1'b0;
    rd = 1'b0;
    reset = 1'b1;
    modelReset();
    doReset();

    #1;
    checkOutput("rst.empty", 32'(empty), 32'd1);
    checkOutput("rst.full",  32'(full),  32'd0);
    checkOutput("rst.count", 32'(count), 32'd0);
    checkOutput("rst.waddr", 32'(wAddr), 32'd0);
    checkOutput("rst.raddr", 32'(rAddr), 32'd0);
    checkOutput("rst.we",    32'(we),    32'd0);
    repeat (2) applyStimulus(1'b0, 1'b0, "idle");

    // Fill, then one write too many
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, "fill");
    checkOutput("fill.fullNow", 32'(full),  32'd1);
    checkOutput("fill.count8",  32'(count), 32'd8);
    applyStimulus(1'b1, 1'b0, "fillOver");

    // Drain, then one read too many
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, "drain");
    checkOutput("drain.emptyNow", 32'(empty), 32'd1);
    applyStimulus(1'b0, 1'b1, "drainUnder");

    // Simultaneous at count=3
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, "pre3");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, "both3");
    checkOutput("both3.count", 32'(count), 32'd3);
    checkOutput("both3.waddr", 32'(wAddr), 32'd0);
    checkOutput("both3.raddr", 32'(rAddr), 32'd5);

    // Simultaneous at empty
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, "toEmpty");
    applyStimulus(1'b1, 1'b1, "bothEmpty");
    checkOutput("bothEmpty.count", 32'(count), 32'd1);

    // Simultaneous at full
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, "toFull");
    applyStimulus(1'b1, 1'b1, "bothFull");
    checkOutput("bothFull.count", 32'(count), 32'd7);

    // Wrap-around integrity from a fresh reset
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, "wrapW5");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, "wrapR5");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, "wrapW8");
    checkOutput("wrap.full",  32'(full),  32'd1);
    checkOutput("wrap.waddr", 32'(wAddr), 32'd5);
    checkOutput("wrap.raddr", 32'(rAddr), 32'd5);

    // Asynchronous reset between edges with count=4
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, "mid");
    wr = 1'b0;
    rd = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async.count", 32'(count), 32'd0);
    checkOutput("async.empty", 32'(empty), 32'd1);
    checkOutput("async.full",  32'(full),  32'd0);
    checkOutput("async.waddr", 32'(wAddr), 32'd0);
    checkOutput("async.raddr", 32'(rAddr), 32'd0);
    checkOutput("async.we",    32'(we),    32'd0);
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, "postRst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller that sits directly upstream of the register file.
- Drives the register file's write enable, write address and read address, turning that storage into a circular FIFO.
- Tracks occupancy and produces full, empty and count status for the producer and the consumer.
- Read data comes from the register file's combinational read port at r_addr; this block never touches data.

Parameters:
- N, 3, address width; FIFO depth is 2**N entries; must match the register file's N.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr  input  1  write request from the producer.
- rd  input  1  read/pop request from the consumer.
- we  output  1  write enable to the register file; equals wr & ~full.
- w_addr  output  N  write address to the register file; equals the write pointer.
- r_addr  output  N  read address to the register file; equals the read pointer.
- full  output  1  FIFO holds 2**N entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  N+1  current occupancy, 0 to 2**N.

Behaviour:
- Reset (asynchronous, immediate on reset high):
  - w_ptr=0, r_ptr=0, count=0.
  - full=0, empty=1, we=0.
  - Any operation in progress is discarded.
- Registered state: w_ptr[N-1:0], r_ptr[N-1:0], full_reg, empty_reg, count_reg. All update on the rising clk edge only.
- Outputs: w_addr=w_ptr and r_addr=r_ptr, taken directly from the registers. we is combinational from wr and full_reg.
- Pointer arithmetic is modulo 2**N; the pointer after 2**N-1 is 0.
- Qualified requests:
  - wr_ok = wr & ~full
  - rd_ok = rd & ~empty
- Per cycle, by {wr_ok, rd_ok}:
  - 00: no change.
  - 10 (write only):
    - w_ptr+1, count+1, empty<=0.
    - full<=1 if w_ptr+1 == r_ptr.
  - 01 (read only):
    - r_ptr+1, count-1, full<=0.
    - empty<=1 if r_ptr+1 == w_ptr.
  - 11 (write and read): both pointers +1; count, full and empty unchanged.
- Boundary cases:
  - Write when full: ignored. we=0, no state change.
  - Read when empty: ignored. Pointers unchanged, empty stays 1.
  - wr=rd=1 while empty: write only (rd is not qualified). Next cycle count=1, empty=0.
  - wr=rd=1 while full: read is qualified and frees a slot, but wr_ok=0 because full=1. Treated as read only; next cycle count=2**N-1, full=0.
- Read timing: the consumer samples the register file read data in the same cycle it asserts rd. r_addr advances after the edge.
- Write latency: data written at edge k is readable (empty=0) from cycle k+1.
- Invariants:
  - count == (w_ptr - r_ptr) mod 2**N, except when full, where count == 2**N.
  - full and empty are never both 1.

Optional Feature:
- Macro: FIFO_CTRL_ERR_FLAGS_EN.
- Defined:
  - Two extra outputs, overflow and underflow, each 1 bit, sticky, reset to 0.
  - overflow sets on any cycle with wr & full.
  - underflow sets on any cycle with rd & empty & ~wr.
  - Both clear only on reset.
- Undefined: the ports do not exist and the behaviour is otherwise identical.

Decomposition:
- Shared header/package:
  - Default N.
  - Localparam DEPTH = 2**N.
  - Op encodings for {wr_ok, rd_ok}: OP_NONE, OP_WR, OP_RD, OP_BOTH.
- One natural sub-module: fifo_ptr.
  - N-bit modulo pointer register with asynchronous reset, an inc input, and ptr and ptr_next outputs.
  - Instantiated twice, for the write and read pointers.
- A top-level wrapper pairs fifo_ctrl with the register file. That wrapper is a separate block.

Test Plan:
- Reset then idle: reset=1 for 2 cycles then release, no wr/rd. Expect empty=1, full=0, count=0, w_addr=0, r_addr=0, we=0.
- Fill (N=3): 8 consecutive wr. we=1 each cycle; w_addr steps 0..7 then wraps to 0; after the 8th edge full=1, count=8. A 9th wr gives we=0 and no change (overflow=1 with the macro defined).
- Drain: from full, 8 rd. r_addr steps 0..7 then 0; count decrements to 0; empty=1 after the 8th edge. A 9th rd changes nothing (underflow=1 with the macro defined).
- Simultaneous operations:
  - At count=3, wr=rd=1 for 5 cycles: count stays 3 and both pointers advance by 5 mod 8.
  - At empty with wr=rd=1: count=1, empty=0.
  - At full with wr=rd=1: count=7, full=0, we=0.
- Wrap-around integrity: write 5, read 5, write 8. full=1, w_ptr==r_ptr==5, count=8.
- Reset mid-operation: assert reset asynchronously between edges while count=4. Outputs return to reset values immediately, without waiting for the next clk edge.
